// File: rtl/mp_arb_pkg.sv
// Shared types and sizing helpers for the multiprocessor Avalon-MM round-robin arbiter.
package mp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Watchdog must be able to hold TIMEOUT_CYC-1 as its last value before expiry.
  function automatic int unsigned wd_width(input int unsigned t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mp_avmm_rr_arbiter_pick.sv
// Combinational round-robin picker: rotate requests by the pointer, take the lowest set bit, rotate back.
module mp_rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic [N-1:0]  mask_i,
  output logic          vld_o,
  output logic [IW-1:0] idx_o
);

  logic [N-1:0] eff;
  logic [N-1:0] rot;
  int unsigned  first;
  int unsigned  sum;

  assign eff   = req_i & mask_i;
  assign rot   = N'({eff, eff} >> ptr_i);
  assign vld_o = |eff;

  always_comb begin
    first = 0;
    for (int unsigned j = N; j > 0; j--) begin
      if (rot[j-1]) first = j - 1;
    end
    sum = 32'(ptr_i) + first;
    if (sum >= N) sum = sum - N;
    idx_o = IW'(sum);
  end

endmodule

// File: rtl/mp_avmm_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave between NUM_MASTERS masters, with stall watchdog.
// Optional grant locking via ARB_LOCK_EN; without it m_lock is ignored.
module mp_avmm_rr_arbiter
  import mp_arb_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 2,
  parameter  int unsigned ADDR_W      = 4,
  parameter  int unsigned DATA_W      = 32,
  parameter  int unsigned TIMEOUT_CYC = 255,
  localparam int unsigned IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
  input  logic [NUM_MASTERS-1:0]        m_lock,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [NUM_MASTERS-1:0]        m_waitrequest,
  output logic [ADDR_W-1:0]             s_address,
  output logic                          s_read,
  output logic                          s_write,
  output logic [DATA_W-1:0]             s_writedata,
  input  logic [DATA_W-1:0]             s_readdata,
  input  logic                          s_waitrequest,
  output logic                          arb_timeout,
  output logic [IDX_W-1:0]              grant_idx
);

  localparam int unsigned     WD_W    = wd_width(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              tmo_q, tmo_d;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] pick_mask;
  logic [IDX_W-1:0]       pick_ptr;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_vld;
  logic [IDX_W-1:0]       grant_next;

  assign req        = m_read | m_write;
  assign grant_next = IDX_W'(wrap_inc(32'(grant_q), NUM_MASTERS));

`ifdef ARB_LOCK_EN
  logic lock_q, lock_d;
  logic lock_exit;

  // The owner is always grant_q while locked; releasing the lock hands priority to owner+1 this same cycle.
  assign lock_exit = lock_q & ~m_lock[grant_q];

  always_comb begin
    pick_ptr  = lock_exit ? grant_next : ptr_q;
    pick_mask = (lock_q && !lock_exit) ? (NUM_MASTERS'(1) << grant_q) : '1;
  end
`else
  logic unused_lock;
  assign unused_lock = ^m_lock;
  assign pick_ptr    = ptr_q;
  assign pick_mask   = '1;
`endif

  mp_rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IDX_W)
  ) u_pick (
    .req_i  (req),
    .ptr_i  (pick_ptr),
    .mask_i (pick_mask),
    .vld_o  (pick_vld),
    .idx_o  (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    wd_d    = wd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    tmo_d   = 1'b0;
`ifdef ARB_LOCK_EN
    lock_d  = lock_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef ARB_LOCK_EN
        if (lock_exit) begin
          lock_d = 1'b0;
          ptr_d  = grant_next;
        end
`endif
        if (pick_vld) begin
          grant_d = pick_idx;
          addr_d  = m_address[pick_idx*ADDR_W +: ADDR_W];
          wdata_d = m_writedata[pick_idx*DATA_W +: DATA_W];
          wr_d    = m_write[pick_idx];
          rd_d    = ~m_write[pick_idx];
          wd_d    = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A completion in the expiry cycle still counts as a completion.
        if (!s_waitrequest) begin
          if (rd_q) rdata_d = s_readdata;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          rdata_d = '0;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      RESP: begin
        ptr_d   = grant_next;
        state_d = IDLE;
`ifdef ARB_LOCK_EN
        if (m_lock[grant_q]) begin
          lock_d = 1'b1;
          ptr_d  = ptr_q;
        end else begin
          lock_d = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      wd_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      wd_q    <= wd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clk_clk) begin
    if (reset_reset) lock_q <= 1'b0;
    else             lock_q <= lock_d;
  end
`endif

  always_comb begin
    m_waitrequest = '1;
    if (state_q == RESP) m_waitrequest[grant_q] = 1'b0;
  end

  // Strobes are cut combinationally by reset so an in-flight command drops without waiting for an edge.
  assign s_read      = rd_q & ~reset_reset;
  assign s_write     = wr_q & ~reset_reset;
  assign s_address   = addr_q;
  assign s_writedata = wdata_q;
  assign m_readdata  = rdata_q;
  assign arb_timeout = tmo_q;
  assign grant_idx   = grant_q;

endmodule

// File: tb/tb_mp_avmm_rr_arbiter.sv
// Directed bench for mp_avmm_rr_arbiter: two masters, 8-cycle watchdog, memory-backed slave.
module tb_mp_avmm_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [7:0]  m_address;
  logic [1:0]  m_read, m_write, m_lock;
  logic [63:0] m_writedata;
  logic [31:0] m_readdata;
  logic [1:0]  m_waitrequest;
  logic [3:0]  s_address;
  logic        s_read, s_write;
  logic [31:0] s_writedata, s_readdata;
  logic        s_waitrequest;
  logic        arb_timeout;
  logic [0:0]  grant_idx;

  logic [31:0] mem [16];
  int vectors = 0;
  int errs    = 0;

  assign s_readdata = mem[s_address];

  mp_avmm_rr_arbiter #(
    .NUM_MASTERS (2),
    .ADDR_W      (4),
    .DATA_W      (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk_clk       (clk),
    .reset_reset   (rst),
    .m_address     (m_address),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_lock        (m_lock),
    .m_readdata    (m_readdata),
    .m_waitrequest (m_waitrequest),
    .s_address     (s_address),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_writedata   (s_writedata),
    .s_readdata    (s_readdata),
    .s_waitrequest (s_waitrequest),
    .arb_timeout   (arb_timeout),
    .grant_idx     (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int          lock_exp [4];
    logic [1:0]  wexp;
    int          g;

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[1] = 32'h11;
    mem[2] = 32'h22;
    mem[5] = 32'h55;
    mem[7] = 32'hCAFE_F00D;
    mem[9] = 32'hDEAD_BEEF;

`ifdef ARB_LOCK_EN
    lock_exp = '{1, 1, 1, 0};
`else
    lock_exp = '{1, 0, 1, 0};
`endif

    rst = 1'b1;
    m_address = '0; m_read = '0; m_write = '0; m_lock = '0; m_writedata = '0;
    s_waitrequest = 1'b0;

    // Reset values
    nxt(); nxt();
    chk("rst_wreq",  m_waitrequest, 2'b11);
    chk("rst_sread", s_read, 1'b0);
    chk("rst_swrite", s_write, 1'b0);
    chk("rst_saddr", s_address, 4'h0);
    chk("rst_swdata", s_writedata, 32'h0);
    chk("rst_rdata", m_readdata, 32'h0);
    chk("rst_tmo",   arb_timeout, 1'b0);
    chk("rst_grant", grant_idx, 1'b0);
    rst = 1'b0;

    // Single write from M0, zero-wait slave
    nxt();
    chk("w_idle_wreq", m_waitrequest, 2'b11);
    m_address[3:0] = 4'd3; m_writedata[31:0] = 32'hA5A5_0001; m_write[0] = 1'b1;
    nxt();
    chk("w_swrite", s_write, 1'b1);
    chk("w_sread", s_read, 1'b0);
    chk("w_saddr", s_address, 4'd3);
    chk("w_sdata", s_writedata, 32'hA5A5_0001);
    chk("w_c1_wreq", m_waitrequest, 2'b11);
    nxt();
    chk("w_c2_wreq", m_waitrequest, 2'b10);
    chk("w_grant", grant_idx, 1'b0);
    m_write = '0;
    nxt();
    chk("w_c3_wreq", m_waitrequest, 2'b11);
    chk("w_c3_swrite", s_write, 1'b0);

    // M1 read brings the pointer back to 0
    m_address[7:4] = 4'd5; m_read[1] = 1'b1;
    nxt();
    chk("r1_sread", s_read, 1'b1);
    chk("r1_saddr", s_address, 4'd5);
    chk("r1_grant", grant_idx, 1'b1);
    nxt();
    chk("r1_wreq", m_waitrequest, 2'b01);
    chk("r1_rdata", m_readdata, 32'h55);
    m_read = '0;
    nxt();

    // Contention, pointer 0
    m_address = {4'd2, 4'd1}; m_read = 2'b11;
    nxt();
    chk("ct_addr0", s_address, 4'd1);
    chk("ct_grant0", grant_idx, 1'b0);
    nxt();
    chk("ct_wreq0", m_waitrequest, 2'b10);
    chk("ct_rdata0", m_readdata, 32'h11);
    m_read[0] = 1'b0;
    nxt();
    chk("ct_idle_wreq", m_waitrequest, 2'b11);
    nxt();
    chk("ct_addr1", s_address, 4'd2);
    chk("ct_grant1", grant_idx, 1'b1);
    nxt();
    chk("ct_wreq1", m_waitrequest, 2'b01);
    chk("ct_rdata1", m_readdata, 32'h22);
    m_read = '0;
    nxt();

    // Fairness: both masters request continuously for 20 transfers
    m_read = 2'b11;
    for (int t = 0; t < 20; t++) begin
      g = t % 2;
      nxt();
      nxt();
      wexp = (g == 1) ? 2'b01 : 2'b10;
      chk("fair_wreq", m_waitrequest, wexp);
      chk("fair_rdata", m_readdata, (g == 1) ? 32'h22 : 32'h11);
      if (t == 19) m_read = '0;
      nxt();
    end

    // Five slave wait states on a read
    m_address[3:0] = 4'd7; m_read[0] = 1'b1; s_waitrequest = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      nxt();
      chk("ws_sread", s_read, 1'b1);
      chk("ws_wreq", m_waitrequest, 2'b11);
    end
    nxt();
    chk("ws_c6_sread", s_read, 1'b1);
    s_waitrequest = 1'b0;
    nxt();
    chk("ws_c7_wreq", m_waitrequest, 2'b10);
    chk("ws_rdata", m_readdata, 32'hCAFE_F00D);
    chk("ws_tmo", arb_timeout, 1'b0);
    m_read = '0;
    nxt();

    // Watchdog timeout on M1 with a stuck slave
    m_address[7:4] = 4'd9; m_read[1] = 1'b1; s_waitrequest = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      nxt();
      chk("to_pre_tmo", arb_timeout, 1'b0);
      chk("to_pre_sread", s_read, 1'b1);
    end
    nxt();
    chk("to_tmo", arb_timeout, 1'b1);
    chk("to_wreq", m_waitrequest, 2'b01);
    chk("to_rdata", m_readdata, 32'h0);
    chk("to_sread", s_read, 1'b0);
    chk("to_grant", grant_idx, 1'b1);
    m_read = '0; s_waitrequest = 1'b0;
    nxt();
    chk("to_tmo_clr", arb_timeout, 1'b0);
    chk("to_wreq_idle", m_waitrequest, 2'b11);
    m_address[3:0] = 4'd1; m_read[0] = 1'b1;
    nxt();
    nxt();
    chk("to_after_wreq", m_waitrequest, 2'b10);
    chk("to_after_rdata", m_readdata, 32'h11);
    m_read = '0;
    nxt();

    // Read and write together are treated as a write; readdata is preserved
    m_address[3:0] = 4'd4; m_writedata[31:0] = 32'h0BAD_BEEF; m_read[0] = 1'b1; m_write[0] = 1'b1;
    nxt();
    chk("rw_swrite", s_write, 1'b1);
    chk("rw_sread", s_read, 1'b0);
    chk("rw_sdata", s_writedata, 32'h0BAD_BEEF);
    nxt();
    chk("rw_wreq", m_waitrequest, 2'b10);
    chk("rw_rdata_kept", m_readdata, 32'h11);
    m_read = '0; m_write = '0;
    nxt();

    // Reset in the middle of a stalled transfer
    m_address[7:4] = 4'd2; m_read[1] = 1'b1; s_waitrequest = 1'b1;
    nxt();
    chk("mr_sread", s_read, 1'b1);
    nxt();
    rst = 1'b1;
    #1;
    chk("mr_sread_drop", s_read, 1'b0);
    nxt();
    chk("mr_wreq", m_waitrequest, 2'b11);
    chk("mr_grant", grant_idx, 1'b0);
    chk("mr_rdata", m_readdata, 32'h0);
    chk("mr_saddr", s_address, 4'h0);
    rst = 1'b0; m_read = '0; s_waitrequest = 1'b0;
    nxt();
    m_address = {4'd2, 4'd1}; m_read = 2'b11;
    nxt();
    chk("mr_ptr_grant", grant_idx, 1'b0);
    chk("mr_ptr_addr", s_address, 4'd1);
    nxt();
    chk("mr_ptr_wreq", m_waitrequest, 2'b10);
    m_read = '0;
    nxt();

    // M1 holds m_lock for three transfers while M0 also requests
    m_lock = 2'b10; m_read = 2'b11;
    for (int t = 0; t < 4; t++) begin
      nxt();
      nxt();
      wexp = (lock_exp[t] == 1) ? 2'b01 : 2'b10;
      chk("lk_wreq", m_waitrequest, wexp);
      chk("lk_grant", grant_idx, lock_exp[t][0]);
      if (t == 2) m_lock = '0;
      if (t == 3) m_read = '0;
      nxt();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
